ray_inv_dir_unit: RTL and testbench

- Computes the fixed-point reciprocal of each component of a ray direction vector (1/dx, 1/dy, 1/dz) for slab-test ray/AABB intersection in the path tracer.
- Parametrised successor to the single-lane IP-based reciprocal: multi-channel, with a valid/ready handshake on both sides, a per-channel divide-by-zero flag and saturation.
- Uses one shared iterative radix-2 restoring divider, time-multiplexed across channels, to minimise LUT/DSP use.
- Sits between ray generation and the BVH traversal front end.

---
 rtl/ray_inv_dir_unit_pkg.sv | 21 ++
 rtl/ray_inv_dir_unit_if.sv | 30 +++
 rtl/ray_inv_dir_unit_recip_radix2_core.sv | 56 +++++
 rtl/ray_inv_dir_unit.sv | 121 ++++++++++++
 tb/tb_ray_inv_dir_unit.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ray_inv_dir_unit_pkg.sv
// Shared defaults, vector typedefs and the controller state encoding for the
// ray inverse-direction unit.
package ray_inv_dir_unit_pkg;

   localparam int NUM_CH_DEF = 3;
   localparam int IN_W_DEF   = 32;
   localparam int FRAC_DEF   = 16;
   localparam int OUT_W_DEF  = IN_W_DEF + 2;

   typedef logic signed [IN_W_DEF-1:0]  ray_dir_t [NUM_CH_DEF];
   typedef logic signed [OUT_W_DEF-1:0] inv_dir_t [NUM_CH_DEF];

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      DIV,
      FIN,
      OUT
   } state_t;

endpackage

// File: rtl/ray_inv_dir_unit_if.sv
// Request/response bundle between ray generation, the reciprocal unit and
// the BVH traversal front end.
interface ray_inv_dir_unit_if
   import ray_inv_dir_unit_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int IN_W   = IN_W_DEF,
   parameter int OUT_W  = IN_W + 2
) ();

   logic                    in_valid;
   logic                    in_ready;
   logic [NUM_CH*IN_W-1:0]  in_dir;
   logic                    out_valid;
   logic                    out_ready;
   logic [NUM_CH*OUT_W-1:0] out_inv;
   logic [NUM_CH-1:0]       out_dbz;
   logic                    busy;

   modport master (
      output in_valid, in_dir, out_ready,
      input  in_ready, out_valid, out_inv, out_dbz, busy
   );

   modport slave (
      input  in_valid, in_dir, out_ready,
      output in_ready, out_valid, out_inv, out_dbz, busy
   );

endinterface

// File: rtl/ray_inv_dir_unit_recip_radix2_core.sv
// Single-channel restoring radix-2 divider computing floor(2^(2*FRAC)/m).
// A start pulse latches m and clears the state; the quotient is complete on
// the edge where done is high (2*FRAC+1 iterations later).
module recip_radix2_core
   import ray_inv_dir_unit_pkg::*;
#(
   parameter int IN_W = IN_W_DEF,
   parameter int FRAC = FRAC_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [IN_W-1:0]   m,
   output logic              done,
   output logic [2*FRAC:0]   q
);

   localparam int QB = 2*FRAC + 1;
   localparam int IW = $clog2(QB + 1);

   logic [IN_W-1:0] m_reg;
   logic [IN_W:0]   rem;
   logic [IN_W:0]   rem_sh;
   logic [IW-1:0]   iter;
   logic            active;
   logic            nbit;
   logic            ge;

   // One restoring step: shift in the next numerator bit and trial-subtract.
   // Only the MSB of 2^(2*FRAC) is set, so it enters on the first iteration.
   always_comb begin
      nbit   = (iter == '0);
      rem_sh = {rem[IN_W-1:0], nbit};
      ge     = rem[IN_W] | (rem_sh >= {1'b0, m_reg});
      done   = active && (iter == IW'(QB - 1));
   end

   // Iteration state; start restarts the division, rst aborts it.
   always_ff @(posedge clk) begin
      if (rst) begin
         active <= 1'b0;
      end else if (start) begin
         active <= 1'b1;
         iter   <= '0;
         rem    <= '0;
         q      <= '0;
         m_reg  <= m;
      end else if (active) begin
         rem  <= ge ? (rem_sh - {1'b0, m_reg}) : rem_sh;
         q    <= {q[QB-2:0], ge};
         iter <= iter + IW'(1);
         if (done) active <= 1'b0;
      end
   end

endmodule

// File: rtl/ray_inv_dir_unit.sv
// Per-component fixed-point reciprocal of a ray direction vector. One shared
// iterative divider is time-multiplexed across the channels; each channel
// takes LOAD + (2*FRAC+1) DIV + FIN cycles, so latency is data-independent.
module ray_inv_dir_unit
   import ray_inv_dir_unit_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int IN_W   = IN_W_DEF,
   parameter int FRAC   = FRAC_DEF
) (
   input logic               sysclk,
   input logic               rst,
   ray_inv_dir_unit_if.slave bus
);

   localparam int OUT_W = IN_W + 2;
   localparam int QB    = 2*FRAC + 1;
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   // The m=1 result 2^(2*FRAC) must fit below the output sign bit.
   if (2*FRAC >= OUT_W - 1) begin : g_width_check
      $error("ray_inv_dir_unit: OUT_W too small for 2^(2*FRAC)");
   end

   state_t                  state, state_n;
   logic [CH_W-1:0]         ch;
   logic [NUM_CH*IN_W-1:0]  dir_reg;
   logic signed [IN_W-1:0]  d_sel;
   logic [IN_W-1:0]         m_sel;
   logic                    neg_reg;
   logic                    zero_reg;
   logic                    core_start;
   logic                    core_done;
   logic [QB-1:0]           core_q;
   logic [NUM_CH*OUT_W-1:0] inv_reg;
   logic [NUM_CH-1:0]       dbz_reg;

   // Magnitude as unsigned; the most negative input maps exactly to 2^(IN_W-1).
   function automatic logic [IN_W-1:0] mag_of(input logic signed [IN_W-1:0] d);
      return d[IN_W-1] ? unsigned'(-d) : unsigned'(d);
   endfunction

   // Restore the sign (truncation toward zero) or saturate a zero divisor.
   function automatic logic signed [OUT_W-1:0] sign_sat(input logic [QB-1:0] qv,
                                                        input logic neg,
                                                        input logic zero);
      logic signed [OUT_W-1:0] mag;
      mag = signed'(OUT_W'(qv));
      if (zero)     return {1'b0, {(OUT_W-1){1'b1}}};
      else if (neg) return -mag;
      else          return mag;
   endfunction

   assign d_sel      = dir_reg[ch*IN_W +: IN_W];
   assign m_sel      = mag_of(d_sel);
   assign core_start = (state == LOAD);

   recip_radix2_core #(
      .IN_W (IN_W),
      .FRAC (FRAC)
   ) u_core (
      .clk   (sysclk),
      .rst   (rst),
      .start (core_start),
      .m     (m_sel),
      .done  (core_done),
      .q     (core_q)
   );

   // Controller state register.
   always_ff @(posedge sysclk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Next-state: walk LOAD/DIV/FIN once per channel, then hold in OUT.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (bus.in_valid) state_n = LOAD;
         LOAD:    state_n = DIV;
         DIV:     if (core_done) state_n = FIN;
         FIN:     state_n = (ch == CH_W'(NUM_CH - 1)) ? OUT : LOAD;
         OUT:     if (bus.out_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Input capture, per-channel sign/zero, and the result register.
   always_ff @(posedge sysclk) begin
      if (rst) begin
         ch      <= '0;
         inv_reg <= '0;
         dbz_reg <= '0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               dir_reg <= bus.in_dir;
               ch      <= '0;
            end
            LOAD: begin
               neg_reg  <= d_sel[IN_W-1];
               zero_reg <= (m_sel == '0);
            end
            FIN: begin
               inv_reg[ch*OUT_W +: OUT_W] <= sign_sat(core_q, neg_reg, zero_reg);
               dbz_reg[ch]                <= zero_reg;
               if (ch != CH_W'(NUM_CH - 1)) ch <= ch + CH_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE) && !rst;
   assign bus.out_valid = (state == OUT);
   assign bus.busy      = (state != IDLE);
   assign bus.out_inv   = inv_reg;
   assign bus.out_dbz   = dbz_reg;

endmodule

// File: tb/tb_ray_inv_dir_unit.sv
// Scoreboard bench for ray_inv_dir_unit: stimulus pushes expected vectors
// computed with plain 64-bit arithmetic; a monitor compares whenever the
// unit presents a result.
module tb_ray_inv_dir_unit;

   localparam int NUM_CH = 3;
   localparam int IN_W   = 32;
   localparam int FRAC   = 16;
   localparam int OUT_W  = IN_W + 2;
   localparam int LAT    = NUM_CH * (2*FRAC + 3);

   typedef struct {
      logic [NUM_CH*OUT_W-1:0] inv;
      logic [NUM_CH-1:0]       dbz;
      int                      acc;
   } exp_t;

   logic sysclk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   bit   seen_valid = 1'b0;
   bit   rdy_rand = 1'b0;
   bit   rdy_level = 1'b1;
   exp_t exp_q[$];

   ray_inv_dir_unit_if #(.NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

   ray_inv_dir_unit #(.NUM_CH(NUM_CH), .IN_W(IN_W), .FRAC(FRAC)) dut (
      .sysclk (sysclk),
      .rst    (rst),
      .bus    (bus)
   );

   always #5 sysclk = ~sysclk;
   always @(posedge sysclk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
   endtask

   // Reference: floor(2^(2*FRAC)/|d|) with the sign reapplied; zero saturates.
   function automatic logic [OUT_W-1:0] ref_inv(input logic [IN_W-1:0] raw, output logic z);
      longint d, m, q;
      d = longint'($signed(raw));
      m = (d < 0) ? -d : d;
      if (m == 0) begin
         z = 1'b1;
         return OUT_W'((longint'(1) <<< (OUT_W - 1)) - 1);
      end
      z = 1'b0;
      q = (longint'(1) <<< (2*FRAC)) / m;
      return OUT_W'((d < 0) ? -q : q);
   endfunction

   function automatic logic [IN_W-1:0] gen();
      logic [IN_W-1:0] v;
      case ($urandom_range(0, 7))
         0: v = IN_W'(int'($urandom_range(0, 4)) - 2);
         1: case ($urandom_range(0, 5))
               0: v = 32'h8000_0000;
               1: v = 32'h7FFF_FFFF;
               2: v = 32'h0000_0001;
               3: v = 32'hFFFF_FFFF;
               4: v = 32'h0001_0000;
               default: v = 32'hFFFF_0000;
            endcase
         2: begin
            v = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) v = -v;
         end
         default: v = $urandom;
      endcase
      return v;
   endfunction

   // Wait for in_ready, present one vector for a single accepting edge.
   task automatic send(input logic [NUM_CH*IN_W-1:0] v);
      exp_t e;
      logic z;
      int   n;
      n = 0;
      do begin
         @(negedge sysclk);
         n++;
      end while (!bus.in_ready && n < 1000);
      if (!bus.in_ready) begin
         check("in_ready_timeout", bus.in_ready, 1'b1);
         return;
      end
      bus.in_valid = 1'b1;
      bus.in_dir   = v;
      e.inv = '0;
      e.dbz = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         e.inv[k*OUT_W +: OUT_W] = ref_inv(v[k*IN_W +: IN_W], z);
         e.dbz[k] = z;
      end
      e.acc = cyc + 1;
      exp_q.push_back(e);
      @(negedge sysclk);
      bus.in_valid = 1'b0;
      bus.in_dir   = {$urandom, $urandom, $urandom};
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge sysclk);
         n++;
      end
      if (exp_q.size() != 0) begin
         check("drain_timeout_pending", 128'(exp_q.size()), 128'd0);
         exp_q.delete();
      end
   endtask

   // out_ready driver, changed just after the active edge.
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge sysclk);
         #1;
         bus.out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_level;
      end
   end

   // Monitor: compare every cycle a result is presented, pop on handshake.
   initial begin
      exp_t e;
      forever begin
         @(negedge sysclk);
         if (!rst && bus.out_valid) begin
            if (exp_q.size() == 0) begin
               check("out_valid_unrequested", bus.out_valid, 1'b0);
            end else begin
               e = exp_q[0];
               if (!seen_valid) begin
                  check("latency", 128'(cyc - e.acc), 128'(LAT));
                  seen_valid = 1'b1;
               end
               check("out_inv", bus.out_inv, e.inv);
               check("out_dbz", bus.out_dbz, e.dbz);
               check("in_ready_while_out", bus.in_ready, 1'b0);
               check("busy_while_out", bus.busy, 1'b1);
               if (bus.out_ready) begin
                  void'(exp_q.pop_front());
                  seen_valid = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_dir   = '0;
      repeat (3) @(negedge sysclk);
      check("rst_in_ready", bus.in_ready, 1'b0);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_out_inv", bus.out_inv, '0);
      check("rst_out_dbz", bus.out_dbz, '0);
      rst = 1'b0;
      @(negedge sysclk);
      check("in_ready_after_rst", bus.in_ready, 1'b1);

      // Directed vectors: channel 0 is the least significant slice.
      send({32'h0002_0000, 32'hFFFF_0000, 32'h0001_0000});
      drain();
      send({32'h0000_0001, 32'hFFFD_0000, 32'h0003_0000});
      drain();
      send({32'h0000_8000, 32'h8000_0000, 32'h0000_0000});
      drain();
      send({32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001});
      drain();

      // Backpressure: hold the result, poke in_valid, then release.
      rdy_level = 1'b0;
      send({gen(), gen(), gen()});
      n = 0;
      while (!bus.out_valid && n < 300) begin
         @(negedge sysclk);
         n++;
      end
      check("bp_out_valid_seen", bus.out_valid, 1'b1);
      repeat (20) begin
         @(negedge sysclk);
         bus.in_valid = 1'b1;
         bus.in_dir   = {$urandom, $urandom, $urandom};
      end
      bus.in_valid = 1'b0;
      rdy_level    = 1'b1;
      drain();
      @(negedge sysclk);
      check("in_ready_after_handshake", bus.in_ready, 1'b1);
      send({gen(), gen(), gen()});
      drain();

      // Reset partway through a transaction.
      send({gen(), gen(), gen()});
      repeat (50) @(negedge sysclk);
      rst = 1'b1;
      @(negedge sysclk);
      check("abort_out_valid", bus.out_valid, 1'b0);
      check("abort_busy", bus.busy, 1'b0);
      check("abort_in_ready_in_rst", bus.in_ready, 1'b0);
      check("abort_out_inv", bus.out_inv, '0);
      exp_q.delete();
      seen_valid = 1'b0;
      rst = 1'b0;
      @(negedge sysclk);
      check("abort_in_ready_after", bus.in_ready, 1'b1);
      send({32'h0001_0000, 32'h0001_0000, 32'h0001_0000});
      drain();

      // Random sweep with random output stalls.
      rdy_rand = 1'b1;
      for (int i = 0; i < 500; i++) begin
         send({gen(), gen(), gen()});
      end
      drain();
      rdy_rand = 1'b0;
      repeat (5) @(negedge sysclk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
